// File: rtl/candidate_buffer_pkg.sv
// Shared types for the candidate buffer: FSM states, candidate record, counter limit.
// Latency: n/a (types only).
// Backpressure: n/a.
package candidate_buffer_pkg;

    localparam int COORD_W = 12;
    localparam int STAT_W  = 16;

    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } cand_t;

endpackage

// File: rtl/candidate_buffer_if.sv
// Candidate hit strobe, second-phase valid/ready handshake and frame statistics.
// Latency: n/a (wiring only).
// Backpressure: i_ready from the second phase throttles head entry consumption.
interface candidate_buffer_if #(
    parameter int DATA_WIDTH_12 = 12,
    parameter int DATA_WIDTH_16 = 16,
    parameter int ADDR_WIDTH    = 4
);
    logic                     i_frame_start;
    logic                     i_frame_end;
    logic                     i_candidate;
    logic [DATA_WIDTH_12-1:0] i_scale_xcoord;
    logic [DATA_WIDTH_12-1:0] i_scale_ycoord;
    logic                     o_valid;
    logic                     i_ready;
    logic [DATA_WIDTH_12-1:0] o_xcoord;
    logic [DATA_WIDTH_12-1:0] o_ycoord;
    logic [ADDR_WIDTH:0]      o_count;
    logic                     o_full;
    logic                     o_empty;
    logic [DATA_WIDTH_16-1:0] o_frame_candidates;
    logic [DATA_WIDTH_16-1:0] o_merged_count;
    logic                     o_overflow;
    logic                     o_frame_done;

    modport master (
        output i_frame_start, i_frame_end, i_candidate, i_scale_xcoord, i_scale_ycoord, i_ready,
        input  o_valid, o_xcoord, o_ycoord, o_count, o_full, o_empty,
               o_frame_candidates, o_merged_count, o_overflow, o_frame_done
    );

    modport slave (
        input  i_frame_start, i_frame_end, i_candidate, i_scale_xcoord, i_scale_ycoord, i_ready,
        output o_valid, o_xcoord, o_ycoord, o_count, o_full, o_empty,
               o_frame_candidates, o_merged_count, o_overflow, o_frame_done
    );

endinterface

// File: rtl/candidate_fifo.sv
// Show-ahead candidate FIFO with flush; head is visible whenever the FIFO is non-empty.
// Latency: 1 cycle push-to-head, no bypass.
// Backpressure: push into a full FIFO only succeeds alongside a pop; pop on empty is ignored.
module candidate_fifo
    import candidate_buffer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic            clk_fpga,
    input  logic            reset_fpga,
    input  logic            flush,
    input  logic            push,
    input  cand_t           push_dat,
    input  logic            pop,
    output cand_t           head_dat,
    output logic            head_vld,
    output logic [ADDR_W:0] count,
    output logic            full,
    output logic            empty
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    cand_t             mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              pop_ok;
    logic              push_ok;

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_C);
    assign head_vld = !empty;
    // Head reads zero when empty so the outputs stay defined after reset/flush.
    assign head_dat = empty ? '0 : mem[rd_ptr];
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);

    always_ff @(posedge clk_fpga or negedge reset_fpga) begin
        if (!reset_fpga) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_fpga) begin
        if (push_ok && !flush) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/candidate_buffer.sv
// Drops near-duplicate first-phase hits, queues the rest for the second phase, tracks frame stats.
// Latency: 1 cycle from accepted hit to o_valid; o_frame_done 1 cycle after an empty DRAIN.
// Backpressure: o_valid/i_ready on the head; hits arriving with no space are lost and flag o_overflow.
module candidate_buffer
    import candidate_buffer_pkg::*;
#(
    parameter int DATA_WIDTH_12 = 12,
    parameter int DATA_WIDTH_16 = 16,
    parameter int FIFO_DEPTH    = 16,
    parameter int ADDR_WIDTH    = 4,
    parameter int MERGE_DIST    = 2
) (
    input  logic               clk_fpga,
    input  logic               reset_fpga,
    candidate_buffer_if.slave  bus
);

    localparam logic [DATA_WIDTH_12:0] MERGE_LIM = (DATA_WIDTH_12+1)'(MERGE_DIST);

    state_t                     state;
    state_t                     state_nxt;
    logic                       done_nxt;
    logic [DATA_WIDTH_12-1:0]   last_x;
    logic [DATA_WIDTH_12-1:0]   last_y;
    logic                       last_vld;
    logic [DATA_WIDTH_16-1:0]   frame_cands;
    logic [DATA_WIDTH_16-1:0]   merged_cnt;
    logic                       overflow;
    logic                       frame_done;
    cand_t                      head_dat;
    cand_t                      hit_dat;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       pop;
    logic                       hit;
    logic                       dup;
    logic                       want_push;
    logic                       push;
    logic                       lost;
    logic signed [DATA_WIDTH_12:0] dx_s;
    logic signed [DATA_WIDTH_12:0] dy_s;
    logic [DATA_WIDTH_12:0]     dx;
    logic [DATA_WIDTH_12:0]     dy;

    assign pop  = bus.o_valid && bus.i_ready;
    assign hit  = (state == ACTIVE) && bus.i_candidate && !bus.i_frame_start;

    assign dx_s = $signed({1'b0, bus.i_scale_xcoord}) - $signed({1'b0, last_x});
    assign dy_s = $signed({1'b0, bus.i_scale_ycoord}) - $signed({1'b0, last_y});
    assign dx   = dx_s[DATA_WIDTH_12] ? $unsigned(-dx_s) : $unsigned(dx_s);
    assign dy   = dy_s[DATA_WIDTH_12] ? $unsigned(-dy_s) : $unsigned(dy_s);

    assign dup       = hit && last_vld && (dx <= MERGE_LIM) && (dy <= MERGE_LIM);
    assign want_push = hit && !dup;
    assign push      = want_push && (!fifo_full || pop);
    assign lost      = want_push && !push;
    assign hit_dat   = '{x: bus.i_scale_xcoord, y: bus.i_scale_ycoord};

    candidate_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_WIDTH)
    ) u_fifo (
        .clk_fpga   (clk_fpga),
        .reset_fpga (reset_fpga),
        .flush      (bus.i_frame_start),
        .push       (push),
        .push_dat   (hit_dat),
        .pop        (pop),
        .head_dat   (head_dat),
        .head_vld   (bus.o_valid),
        .count      (bus.o_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign bus.o_xcoord           = head_dat.x;
    assign bus.o_ycoord           = head_dat.y;
    assign bus.o_full             = fifo_full;
    assign bus.o_empty            = fifo_empty;
    assign bus.o_frame_candidates = frame_cands;
    assign bus.o_merged_count     = merged_cnt;
    assign bus.o_overflow         = overflow;
    assign bus.o_frame_done       = frame_done;

    // Last-hit register only follows accepted pushes, so merges compare against queued entries.
    always_ff @(posedge clk_fpga or negedge reset_fpga) begin
        if (!reset_fpga) begin
            last_x      <= '0;
            last_y      <= '0;
            last_vld    <= 1'b0;
            frame_cands <= '0;
            merged_cnt  <= '0;
            overflow    <= 1'b0;
        end else if (bus.i_frame_start) begin
            last_x      <= '0;
            last_y      <= '0;
            last_vld    <= 1'b0;
            frame_cands <= '0;
            merged_cnt  <= '0;
            overflow    <= 1'b0;
        end else begin
            if (push) begin
                last_x   <= bus.i_scale_xcoord;
                last_y   <= bus.i_scale_ycoord;
                last_vld <= 1'b1;
                if (frame_cands != STAT_MAX) frame_cands <= frame_cands + DATA_WIDTH_16'(1);
            end
            if (dup && (merged_cnt != STAT_MAX)) merged_cnt <= merged_cnt + DATA_WIDTH_16'(1);
            if (lost) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk_fpga or negedge reset_fpga) begin
        if (!reset_fpga) begin
            state      <= IDLE;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        if (bus.i_frame_start) begin
            state_nxt = ACTIVE;
        end else begin
            case (state)
                ACTIVE:  if (bus.i_frame_end) state_nxt = DRAIN;
                DRAIN: begin
                    if (fifo_empty) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

endmodule

// File: tb/tb_candidate_buffer.sv
// Bench for candidate_buffer: directed scenarios plus randomized traffic against a queue-based model.
// Latency: n/a.
// Backpressure: i_ready driven directly and randomly.
module tb_candidate_buffer;

    localparam int W     = 12;
    localparam int SW    = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int MD    = 2;
    // {valid, x, y, count, full, empty, cands, merged, overflow, done}; only empty is set at reset
    localparam logic [65:0] RESET_VEC = 66'h4_0000_0000;

    logic clk_fpga   = 1'b0;
    logic reset_fpga = 1'b0;
    always #5 clk_fpga = ~clk_fpga;

    candidate_buffer_if #(.DATA_WIDTH_12(W), .DATA_WIDTH_16(SW), .ADDR_WIDTH(AW)) bus ();

    candidate_buffer #(
        .DATA_WIDTH_12 (W),
        .DATA_WIDTH_16 (SW),
        .FIFO_DEPTH    (DEPTH),
        .ADDR_WIDTH    (AW),
        .MERGE_DIST    (MD)
    ) dut (
        .clk_fpga   (clk_fpga),
        .reset_fpga (reset_fpga),
        .bus        (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: frame phase 0=idle 1=active 2=drain, queue of {x,y}
    int          m_st;
    logic [23:0] m_q[$];
    int          m_lx, m_ly;
    bit          m_lv;
    int          m_cands, m_merged;
    bit          m_ovf, m_done;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        m_st = 0; m_q.delete(); m_lx = 0; m_ly = 0; m_lv = 0;
        m_cands = 0; m_merged = 0; m_ovf = 0; m_done = 0;
    endtask

    task automatic model_step();
        bit pop, hit, dup, drain_empty;
        int x, y;
        x   = int'(bus.i_scale_xcoord);
        y   = int'(bus.i_scale_ycoord);
        pop = (m_q.size() > 0) && bus.i_ready;
        if (bus.i_frame_start) begin
            model_reset();
            m_st = 1;
            return;
        end
        drain_empty = (m_st == 2) && (m_q.size() == 0);
        hit = (m_st == 1) && bus.i_candidate;
        dup = hit && m_lv && (iabs(x - m_lx) <= MD) && (iabs(y - m_ly) <= MD);
        if (pop) void'(m_q.pop_front());
        if (hit && !dup) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back({12'(x), 12'(y)});
                m_lx = x; m_ly = y; m_lv = 1;
                if (m_cands < 65535) m_cands++;
            end else begin
                m_ovf = 1;
            end
        end
        if (dup && m_merged < 65535) m_merged++;
        m_done = drain_empty;
        if (m_st == 1 && bus.i_frame_end) m_st = 2;
        else if (drain_empty) m_st = 0;
    endtask

    function automatic logic [65:0] exp_vec();
        logic [11:0] hx, hy;
        hx = '0; hy = '0;
        if (m_q.size() > 0) begin
            hx = m_q[0][23:12];
            hy = m_q[0][11:0];
        end
        return {m_q.size() > 0, hx, hy, 5'(m_q.size()), m_q.size() == DEPTH, m_q.size() == 0,
                16'(m_cands), 16'(m_merged), m_ovf, m_done};
    endfunction

    function automatic logic [65:0] obs_vec();
        return {bus.o_valid, bus.o_xcoord, bus.o_ycoord, bus.o_count, bus.o_full, bus.o_empty,
                bus.o_frame_candidates, bus.o_merged_count, bus.o_overflow, bus.o_frame_done};
    endfunction

    task automatic drive(input bit fs, input bit fe, input bit c, input int x, input int y, input bit r);
        bus.i_frame_start  = fs;
        bus.i_frame_end    = fe;
        bus.i_candidate    = c;
        bus.i_scale_xcoord = 12'(x);
        bus.i_scale_ycoord = 12'(y);
        bus.i_ready        = r;
    endtask

    task automatic tick();
        @(posedge clk_fpga);
        model_step();
        @(negedge clk_fpga);
    endtask

    task automatic test_reset();
        drive(0, 0, 1, 5, 5, 1);
        repeat (2) @(negedge clk_fpga);
        n_cmp++;
        if (obs_vec() !== RESET_VEC) begin
            n_err++; $display("FAIL reset_values got %h exp %h", obs_vec(), RESET_VEC);
        end
        model_reset();
        reset_fpga = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, (i == 1), 1, 20 * i, 7, 1);
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL reset_idle_ignore%0d got %h exp %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_basic();
        drive(1, 0, 1, 99, 99, 1); tick();
        drive(0, 0, 1, 10, 10, 1); tick();
        n_cmp++;
        if (bus.o_valid !== 1'b1 || bus.o_xcoord !== 12'd10 || bus.o_ycoord !== 12'd10) begin
            n_err++; $display("FAIL basic_head0 got v=%0b (%0d,%0d) exp v=1 (10,10)", bus.o_valid, bus.o_xcoord, bus.o_ycoord);
        end
        drive(0, 0, 1, 40, 40, 1); tick();
        n_cmp++;
        if (bus.o_valid !== 1'b1 || bus.o_xcoord !== 12'd40 || bus.o_ycoord !== 12'd40) begin
            n_err++; $display("FAIL basic_head1 got v=%0b (%0d,%0d) exp v=1 (40,40)", bus.o_valid, bus.o_xcoord, bus.o_ycoord);
        end
        drive(0, 0, 0, 0, 0, 1); tick();
        n_cmp++;
        if (bus.o_frame_candidates !== 16'd2 || bus.o_valid !== 1'b0) begin
            n_err++; $display("FAIL basic_stats got cands=%0d v=%0b exp cands=2 v=0", bus.o_frame_candidates, bus.o_valid);
        end
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_err++; $display("FAIL basic_model got %h exp %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_merge();
        int xs[3] = '{100, 101, 103};
        int ys[3] = '{50, 52, 50};
        drive(1, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, xs[i], ys[i], 0); tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL merge_step%0d got %h exp %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (bus.o_merged_count !== 16'd1 || bus.o_frame_candidates !== 16'd2 || bus.o_count !== 5'd2) begin
            n_err++; $display("FAIL merge_counts got merged=%0d cands=%0d cnt=%0d exp 1 2 2",
                              bus.o_merged_count, bus.o_frame_candidates, bus.o_count);
        end
    endtask

    task automatic test_overflow();
        drive(1, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 17; i++) begin
            drive(0, 0, 1, 8 * i, 7, 0); tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL ovf_fill%0d got %h exp %h", i, obs_vec(), exp_vec());
            end
            if (i == 15) begin
                n_cmp++;
                if (bus.o_full !== 1'b1 || bus.o_overflow !== 1'b0) begin
                    n_err++; $display("FAIL ovf_full16 got full=%0b ovf=%0b exp full=1 ovf=0", bus.o_full, bus.o_overflow);
                end
            end
        end
        n_cmp++;
        if (bus.o_count !== 5'd16 || bus.o_overflow !== 1'b1 || bus.o_frame_candidates !== 16'd16) begin
            n_err++; $display("FAIL ovf_drop17 got cnt=%0d ovf=%0b cands=%0d exp 16 1 16",
                              bus.o_count, bus.o_overflow, bus.o_frame_candidates);
        end
        drive(0, 0, 1, 500, 500, 1); tick();
        n_cmp++;
        if (bus.o_count !== 5'd16 || bus.o_frame_candidates !== 16'd17 || bus.o_xcoord !== 12'd8) begin
            n_err++; $display("FAIL ovf_full_pushpop got cnt=%0d cands=%0d x=%0d exp 16 17 8",
                              bus.o_count, bus.o_frame_candidates, bus.o_xcoord);
        end
    endtask

    task automatic test_drain();
        int dones;
        dones = 0;
        drive(1, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 30 * i + 5, 9, 0); tick();
        end
        drive(0, 1, 0, 0, 0, 0); tick();
        drive(0, 0, 1, 700, 700, 0); tick();
        n_cmp++;
        if (bus.o_count !== 5'd3 || bus.o_frame_candidates !== 16'd3) begin
            n_err++; $display("FAIL drain_ignore got cnt=%0d cands=%0d exp 3 3", bus.o_count, bus.o_frame_candidates);
        end
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, 0, 1); tick();
            if (bus.o_frame_done === 1'b1) dones++;
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL drain_step%0d got %h exp %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (dones != 1) begin
            n_err++; $display("FAIL drain_done_pulses got %0d exp 1", dones);
        end
        drive(0, 0, 1, 900, 900, 1); tick();
        n_cmp++;
        if (bus.o_count !== 5'd0 || bus.o_frame_candidates !== 16'd3) begin
            n_err++; $display("FAIL drain_idle got cnt=%0d cands=%0d exp 0 3", bus.o_count, bus.o_frame_candidates);
        end
    endtask

    task automatic test_abort();
        int dones;
        dones = 0;
        drive(1, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 40 * i, 11, 0); tick();
        end
        drive(0, 1, 1, 2, 12, 0); tick();
        drive(1, 0, 0, 0, 0, 0); tick();
        n_cmp++;
        if (bus.o_empty !== 1'b1 || bus.o_frame_candidates !== 16'd0 || bus.o_merged_count !== 16'd0
            || bus.o_overflow !== 1'b0 || bus.o_frame_done !== 1'b0) begin
            n_err++; $display("FAIL abort_clear got empty=%0b cands=%0d merged=%0d ovf=%0b done=%0b exp 1 0 0 0 0",
                              bus.o_empty, bus.o_frame_candidates, bus.o_merged_count, bus.o_overflow, bus.o_frame_done);
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 1); tick();
            if (bus.o_frame_done === 1'b1) dones++;
        end
        n_cmp++;
        if (dones != 0 || obs_vec() !== exp_vec()) begin
            n_err++; $display("FAIL abort_no_done got dones=%0d vec=%h exp dones=0 vec=%h", dones, obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        bit fs, fe, c, r, wide;
        int x, y;
        drive(1, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 3000; i++) begin
            fs   = ($urandom_range(0, 149) == 0);
            fe   = ($urandom_range(0, 59) == 0);
            c    = ($urandom_range(0, 1) == 0);
            r    = ($urandom_range(0, 2) == 0);
            wide = ($urandom_range(0, 3) == 0);
            x    = wide ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 12));
            y    = wide ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 12));
            drive(fs, fe, c, x, y, r);
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL random_cycle%0d got %h exp %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 1, 60, 60, 0); tick();
        drive(0, 0, 1, 300, 300, 0);
        #2 reset_fpga = 1'b0;
        #1;
        n_cmp++;
        if (obs_vec() !== RESET_VEC) begin
            n_err++; $display("FAIL reset_async got %h exp %h", obs_vec(), RESET_VEC);
        end
        model_reset();
        @(posedge clk_fpga);
        @(negedge clk_fpga);
        reset_fpga = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 100 * i, 3, 1); tick();
        end
        n_cmp++;
        if (obs_vec() !== exp_vec() || bus.o_count !== 5'd0) begin
            n_err++; $display("FAIL reset_ignore_hits got %h exp %h", obs_vec(), exp_vec());
        end
        drive(1, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 1, 77, 88, 0); tick();
        n_cmp++;
        if (obs_vec() !== exp_vec() || bus.o_xcoord !== 12'd77) begin
            n_err++; $display("FAIL reset_restart got %h exp %h", obs_vec(), exp_vec());
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        test_reset();
        test_basic();
        test_merge();
        test_overflow();
        test_drain();
        test_abort();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
